// File: rtl/lenet_pkg.sv
// Shared LeNet types and constants: channel count, layer-1 map size, pixel type
// and the broadcaster state encoding.
package lenet_pkg;

  localparam int NUM_IN_CH  = 6;
  localparam int L1_MAPSIZE = 14;

  typedef logic signed [7:0] pixel_t;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_START,
    ST_GAP,
    ST_STREAM,
    ST_PEND
  } bcast_state_t;

endpackage

// File: rtl/fmap_channel_buffer.sv
// One channel of pooled feature-map storage: simple dual-port RAM with a
// synchronous write port and a registered, one-cycle-latency read port.
module fmap_channel_buffer
  import lenet_pkg::*;
#(
  parameter int DEPTH = L1_MAPSIZE * L1_MAPSIZE,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pixel_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output pixel_t        rd_data
);

  // Contents are deliberately not reset so the array maps onto block RAM.
  pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/l1_fmap_broadcaster.sv
// Buffers a full 6-channel layer-1 feature map, then replays it NUM_PASSES times
// as lane-aligned raster streams, each pass announced by a start pulse.
module l1_fmap_broadcaster
  import lenet_pkg::*;
#(
  parameter int MAPSIZE    = L1_MAPSIZE,
  parameter int NUM_PASSES = 1,
  parameter int START_GAP  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic   [NUM_IN_CH-1:0]       wr_valid,
  input  pixel_t [NUM_IN_CH-1:0]       wr_pixel,
  output logic                         wr_ready,
  output logic                         start_out,
  output logic   [NUM_IN_CH-1:0]       data_valid_out,
  output pixel_t [NUM_IN_CH-1:0]       pixel_out,
  output logic                         pass_done,
  output logic                         all_done,
  output logic                         overflow
);

  localparam int DEPTH = MAPSIZE * MAPSIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_BEAT = AW'(DEPTH - 1);

  bcast_state_t         state, next_state;
  logic [CW-1:0]        wr_cnt [NUM_IN_CH];
  logic [NUM_IN_CH-1:0] wr_en;
  logic [AW-1:0]        beat_cnt, rd_addr;
  logic [2:0]           gap_cnt;
  logic [4:0]           pass_cnt;
  logic                 all_full, last_pass;

  // all_full looks ahead by one write so START follows the completing write directly.
  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < NUM_IN_CH; c++) begin
      wr_en[c] = wr_ready && wr_valid[c] && (wr_cnt[c] != FULL);
      if ((wr_cnt[c] + CW'(wr_en[c])) != FULL) all_full = 1'b0;
    end
  end

  assign last_pass = (pass_cnt + 5'd1) == 5'(NUM_PASSES);

  always_comb begin
    next_state = state;
    rd_addr    = '0;
    case (state)
      ST_FILL:   if (all_full) next_state = ST_START;
      ST_START:  next_state = (START_GAP == 0) ? ST_STREAM : ST_GAP;
      ST_GAP:    if (int'(gap_cnt) == START_GAP - 1) next_state = ST_STREAM;
      ST_STREAM: if (beat_cnt == LAST_BEAT) next_state = ST_PEND;
      ST_PEND:   next_state = last_pass ? ST_FILL : ST_START;
      default:   next_state = ST_FILL;
    endcase
    // Read address runs one beat ahead to hide the registered RAM read.
    if (state == ST_STREAM && beat_cnt != LAST_BEAT) rd_addr = beat_cnt + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_FILL;
      gap_cnt        <= '0;
      beat_cnt       <= '0;
      pass_cnt       <= '0;
      wr_ready       <= 1'b0;
      start_out      <= 1'b0;
      data_valid_out <= '0;
      pass_done      <= 1'b0;
      all_done       <= 1'b0;
      overflow       <= 1'b0;
      for (int c = 0; c < NUM_IN_CH; c++) wr_cnt[c] <= '0;
    end else begin
      state    <= next_state;
      gap_cnt  <= (state == ST_GAP) ? gap_cnt + 3'd1 : 3'd0;
      beat_cnt <= (state == ST_STREAM) ? beat_cnt + AW'(1) : '0;
      if (state == ST_PEND) pass_cnt <= last_pass ? 5'd0 : pass_cnt + 5'd1;
      for (int c = 0; c < NUM_IN_CH; c++) begin
        if (state == ST_PEND && last_pass) wr_cnt[c] <= '0;
        else if (wr_en[c])                 wr_cnt[c] <= wr_cnt[c] + CW'(1);
      end
      wr_ready       <= (next_state == ST_FILL);
      start_out      <= (next_state == ST_START);
      data_valid_out <= {NUM_IN_CH{next_state == ST_STREAM}};
      pass_done      <= (next_state == ST_PEND);
      all_done       <= (next_state == ST_PEND) && last_pass;
      overflow       <= overflow | (|(wr_valid & ~wr_en));
    end
  end

  for (genvar c = 0; c < NUM_IN_CH; c++) begin : g_ch
    fmap_channel_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[c]),
      .wr_addr (wr_cnt[c][AW-1:0]),
      .wr_data (wr_pixel[c]),
      .rd_addr (rd_addr),
      .rd_data (pixel_out[c])
    );
  end

endmodule

// File: doc/l1_fmap_broadcaster.md
# l1_fmap_broadcaster

Buffers one complete layer-1 pooled feature map: 6 channels of 14×14 signed 8-bit pixels, each channel arriving on its own independent valid/pixel stream. Once all six channels are full, it replays the map as six lane-aligned raster streams, each preceded by a one-cycle start pulse. Its outputs drive the `start`/`data_valid_in[5:0]`/`pixel_in[5:0]` inputs of the layer-2 channel blocks. The replay repeats `NUM_PASSES` times so that layer-2 output channels can be time-multiplexed over fewer engines.

## Interface
Parameters:
- `MAPSIZE`, 14: side length of each input map; each channel holds MAPSIZE² = 196 pixels.
- `NUM_PASSES`, 1: number of full replays per buffered map (1..16).
- `START_GAP`, 2: idle cycles between `start_out` and the first output beat (0..7). This covers the registered start used by the consumer.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  6  per-channel write strobe.
- `wr_pixel`  in  6×8 signed  per-channel pixel, raster order.
- `wr_ready`  out  1  high only in FILL; writes are accepted only while it is high.
- `start_out`  out  1  one-cycle pulse at the start of each pass.
- `data_valid_out`  out  6  all six bits are always equal; high on each output beat.
- `pixel_out`  out  6×8 signed  lane c carries channel c.
- `pass_done`  out  1  one-cycle pulse after the last beat of each pass.
- `all_done`  out  1  one-cycle pulse after the final pass.
- `overflow`  out  1  sticky flag: a write was dropped. Cleared only by `rst`.

## Operation
- States and transitions:
  - FILL → START when all six channel counters equal 196.
  - START → GAP, or START → STREAM if `START_GAP`=0.
  - GAP → STREAM after `START_GAP` cycles.
  - STREAM → PEND after beat 195.
  - PEND → START if more passes remain.
  - PEND → FILL after the final pass. Write counters and the pass counter clear on this transition.
- FILL:
  - Each channel has an 8-bit write counter (0..196).
  - When `wr_valid[c]` is high and counter c < 196, `wr_pixel[c]` is written at address counter c and the counter increments.
  - Channels fill at independent rates and in any interleaving.
- Dropped writes. Any `wr_valid[c]` in either of these cases is ignored and sets `overflow`:
  - in FILL, while counter c = 196;
  - in any state other than FILL.
- Last write: a write that completes the final channel is accepted. START follows on the next cycle.
- STREAM:
  - A shared read address runs 0..195 at one beat per cycle, with no back-pressure.
  - Lane c outputs buffer c at that address.
  - Pixels pass through unmodified: no rescaling or saturation.
- PEND: one cycle.
  - `pass_done` pulses and the pass counter increments.
  - `all_done` pulses in the same cycle when the incremented counter equals `NUM_PASSES`.
- Buffer contents persist across passes. They are overwritten only by the next FILL and are not cleared by reset.

## Timing
- Reset values:
  - All outputs are 0 while `rst` is high, including `wr_ready` and `overflow`.
  - State returns to FILL with counters at 0.
  - `wr_ready`=1 on the first cycle after `rst` falls.
- Reset mid-pass: streaming stops immediately. `data_valid_out`, `start_out`, `pass_done` and `all_done` are 0 from the cycle after `rst` is sampled. Partial fill is discarded.
- Fill-to-start: if the last fill write is accepted at cycle W, `start_out`=1 at S = W+1 and `wr_ready`=0 from S.
- Beats: beat k (0..195) appears at cycle S+START_GAP+1+k. Address reads are pre-issued so that the registered RAM read lines up with the beat.
- Pass end: `pass_done` at S+START_GAP+197.
- Next pass: the next pass's `start_out` is at S+START_GAP+198.
- Final pass: `wr_ready` returns to 1 at S+START_GAP+198.
- Pass length: a pass takes START_GAP+198 cycles from `start_out` to the next `start_out`.
- Simultaneous write on the PEND→FILL cycle: the write is dropped, because `wr_ready` is still 0.
- All outputs are registered. There is no combinational input→output path.

## Structure
- Shared package `lenet_pkg` holds:
  - `NUM_IN_CH`=6;
  - `L1_MAPSIZE`=14;
  - `pixel_t` (signed [7:0]);
  - the state enum `bcast_state_t`.
- Sub-module `fmap_channel_buffer`, instantiated 6× via generate:
  - MAPSIZE²×8 simple dual-port RAM;
  - synchronous write, registered read with 1-cycle latency;
  - inferable as block RAM.

## Test plan
- **Basic fill and replay.** Fill each channel with pixel(c,i) = (c·40 + i) mod 256 (as signed), all lanes in lockstep from cycle W−195.
  - `start_out` at W+1.
  - Beat k shows pixel(c,k) on lane c at W+4+k, with `START_GAP`=2.
  - `pass_done` and `all_done` pulse together at W+200.
- **Skewed arrival.** Channel 5 is fed with 3-cycle gaps and channels 0–4 continuously.
  - `start_out` waits for channel 5's 196th write.
  - Output data matches the lockstep case.
- **Multiple passes.** With `NUM_PASSES`=3, expect three identical 196-beat passes.
  - `start_out` pulses exactly 200 cycles apart.
  - `pass_done` pulses 3 times; `all_done` pulses once, on the third.
  - `wr_ready`=1 the following cycle.
- **Dropped writes.**
  - A 197th write to channel 2 during FILL is dropped and sets `overflow`.
  - A write during STREAM is dropped and stream data is unchanged.
  - `overflow` stays 1 until `rst`.
- **Reset mid-stream.** Assert `rst` for 1 cycle at beat 100.
  - `data_valid_out`=0 from the next cycle.
  - `wr_ready`=1 one cycle after `rst` falls.
  - A new full fill replays the new data correctly.
- **Extremes.** Pixels 0x80 (−128) and 0x7F on all lanes, with `START_GAP`=0.
  - Values appear bit-exact.
  - The first beat is at S+1.
